vga_scaler_ctrl: RTL and testbench

- Parametrised successor to the fixed 640x480 VGA output stage: programmable timing, sync polarity, colour depth, framebuffer size and integer pixel replication (SCALE).
- Runs on one system clock with an internal pixel-enable tick instead of a derived clock.
- Holds an inferred dual-port framebuffer written by the CPU side and scanned out as a window placed inside the active area, with a border colour around it.
- Outputs syncs, RGB, data-enable and frame status to the board VGA pins and the processor.

---
 rtl/vga_scaler_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_vga_scaler_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scaler_ctrl.sv
// Purpose: programmable VGA scan-out with an inferred framebuffer window, integer pixel replication and a border colour.
// Latency: 2 pixel ticks from raster counter value to the registered pins; CPU writes land 1 clock after the strobe.
// Backpressure: none; every write strobe is accepted or dropped (out of range, flagged on wr_err), and scan-out is free-running.
module vga_scaler_ctrl #(
  parameter int COLOR_W   = 3,
  parameter int FB_W      = 320,
  parameter int FB_H      = 240,
  parameter int ADDR_W    = 17,
  parameter int SCALE     = 2,
  parameter int WIN_X     = 0,
  parameter int WIN_Y     = 0,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int CLK_DIV   = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic [COLOR_W-1:0] border_color,
  output logic [COLOR_W-1:0] disp_RGB,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic               vblank,
  output logic               frame_start,
  output logic               wr_err
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W      = $clog2(H_TOTAL);
  localparam int V_W      = $clog2(V_TOTAL);
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int REP_W    = (SCALE > 1) ? $clog2(SCALE) : 1;
  localparam int FB_SIZE  = FB_W * FB_H;
  localparam int MEM_AW   = (FB_SIZE > 1) ? $clog2(FB_SIZE) : 1;
  localparam int WIN_XW   = FB_W * SCALE;
  localparam int WIN_YH   = FB_H * SCALE;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam logic HS_ON  = (HSYNC_POL != 0);
  localparam logic VS_ON  = (VSYNC_POL != 0);

  // Configurations that cannot produce a sensible picture are refused at elaboration.
  if (WIN_X >= H_ACTIVE || WIN_Y >= V_ACTIVE) begin : g_bad_window
    $error("vga_scaler_ctrl: window origin lies outside the active area");
  end
  if (SCALE != 1 && SCALE != 2 && SCALE != 4) begin : g_bad_scale
    $error("vga_scaler_ctrl: SCALE must be 1, 2 or 4");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_scaler_ctrl: CLK_DIV must be at least 1");
  end
  if ((2 ** ADDR_W) < FB_SIZE) begin : g_bad_addr
    $error("vga_scaler_ctrl: ADDR_W too narrow for the framebuffer");
  end

  // Pixel tick generation
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  // Divider runs 0..CLK_DIV-1; with CLK_DIV = 1 it stays at 0 and ticks every clock.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Raster counters
  logic [H_W-1:0] hcount;
  logic [V_W-1:0] vcount;
  logic           h_last;
  logic           v_last;

  assign h_last = (hcount == H_W'(H_TOTAL - 1));
  assign v_last = (vcount == V_W'(V_TOTAL - 1));

  // Horizontal/vertical position, advancing once per pixel tick.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (tick) begin
      if (h_last) begin
        hcount <= '0;
        vcount <= v_last ? '0 : vcount + 1'b1;
      end else begin
        hcount <= hcount + 1'b1;
      end
    end
  end

  // Stage 0: decode the current raster position.
  // Range tests use unsigned wrap-around so "below the start" falls out as a huge value.
  logic [31:0] hc;
  logic [31:0] vc;
  logic        h_win;
  logic        v_win;
  logic        s0_active;
  logic        s0_win;
  logic        s0_hs;
  logic        s0_vs;
  logic        s0_vb;
  logic        s0_first;

  assign hc        = 32'(hcount);
  assign vc        = 32'(vcount);
  assign h_win     = ((hc - 32'(WIN_X)) < 32'(WIN_XW));
  assign v_win     = ((vc - 32'(WIN_Y)) < 32'(WIN_YH));
  assign s0_active = (hc < 32'(H_ACTIVE)) && (vc < 32'(V_ACTIVE));
  assign s0_win    = s0_active && h_win && v_win;
  assign s0_hs     = ((hc - 32'(HS_START)) < 32'(H_SYNC));
  assign s0_vs     = ((vc - 32'(VS_START)) < 32'(V_SYNC));
  assign s0_vb     = (vc >= 32'(V_ACTIVE));
  assign s0_first  = (hcount == '0) && (vcount == '0);

  // Framebuffer address without a multiplier: column index plus a running row base,
  // each stepped once every SCALE pixels/lines. The registers always describe the
  // current (hcount, vcount); the window may overhang the active area, so they are
  // driven by the unclipped window and only the read address is clipped.
  logic [MEM_AW-1:0] x_idx;
  logic [MEM_AW-1:0] row_base;
  logic [REP_W-1:0]  x_rep;
  logic [REP_W-1:0]  y_rep;
  logic [MEM_AW-1:0] rd_addr;

  assign rd_addr = s0_win ? (row_base + x_idx) : '0;

  // Column and row stepping; both restart outside the window and at counter wrap.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x_idx    <= '0;
      x_rep    <= '0;
      row_base <= '0;
      y_rep    <= '0;
    end else if (tick) begin
      if (h_last || !h_win) begin
        x_idx <= '0;
        x_rep <= '0;
      end else if (x_rep == REP_W'(SCALE - 1)) begin
        x_rep <= '0;
        x_idx <= x_idx + 1'b1;
      end else begin
        x_rep <= x_rep + 1'b1;
      end

      if (h_last) begin
        if (v_last || !v_win) begin
          row_base <= '0;
          y_rep    <= '0;
        end else if (y_rep == REP_W'(SCALE - 1)) begin
          y_rep    <= '0;
          row_base <= row_base + MEM_AW'(FB_W);
        end else begin
          y_rep <= y_rep + 1'b1;
        end
      end
    end
  end

  // Framebuffer storage
  logic [COLOR_W-1:0] mem [0:FB_SIZE-1];
  logic [COLOR_W-1:0] fb_q;
  logic               wr_ok;

  assign wr_ok = wr_en && (32'(wr_addr) < 32'(FB_SIZE));

  // CPU write port, any clock; out-of-range addresses never reach the array.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[wr_addr[MEM_AW-1:0]] <= wr_data;
    end
  end

  // Scan-out read port, one tick latency; a same-clock write returns the old word.
  always_ff @(posedge clock) begin
    if (tick) begin
      fb_q <= mem[rd_addr];
    end
  end

  // Sticky flag for dropped writes, cleared only by reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_err <= 1'b0;
    end else if (wr_en && !wr_ok) begin
      wr_err <= 1'b1;
    end
  end

  // Stage 1: carry the decoded position alongside the RAM read.
  logic s1_active;
  logic s1_win;
  logic s1_hs;
  logic s1_vs;
  logic s1_vb;
  logic s1_first;

  // Pipeline stage matching the RAM latency; flushed to blanking on reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_active <= 1'b0;
      s1_win    <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_vb     <= 1'b0;
      s1_first  <= 1'b0;
    end else if (tick) begin
      s1_active <= s0_active;
      s1_win    <= s0_win;
      s1_hs     <= s0_hs;
      s1_vs     <= s0_vs;
      s1_vb     <= s0_vb;
      s1_first  <= s0_first;
    end
  end

  // Stage 2: output registers; every pin reflects the same raster position.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      disp_RGB <= '0;
      de       <= 1'b0;
      hsync    <= ~HS_ON;
      vsync    <= ~VS_ON;
      vblank   <= 1'b0;
    end else if (tick) begin
      if (s1_win) begin
        disp_RGB <= fb_q;
      end else if (s1_active) begin
        disp_RGB <= border_color;
      end else begin
        disp_RGB <= '0;
      end
      de     <= s1_active;
      hsync  <= s1_hs ? HS_ON : ~HS_ON;
      vsync  <= s1_vs ? VS_ON : ~VS_ON;
      vblank <= s1_vb;
    end
  end

  // Single-clock pulse on the edge that registers pixel (0,0).
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && s1_first;
    end
  end

endmodule

// File: tb/tb_vga_scaler_ctrl.sv
// Directed bench for vga_scaler_ctrl using two small raster configurations.
// A: CLK_DIV 2, SCALE 2, 4x3 window at (4,1), vsync active-high.
// B: CLK_DIV 1, SCALE 4, 2x2 window at (10,6) clipped by the active area, hsync active-high.
module tb_vga_scaler_ctrl;

  localparam int HT  = 24;
  localparam int VT  = 12;
  localparam int PIX = HT * VT;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n;
  logic       wr_en_a, wr_en_b;
  logic [3:0] wr_addr_a;
  logic [1:0] wr_addr_b;
  logic [2:0] wr_data_a, wr_data_b;
  logic [2:0] border_a, border_b;
  logic [2:0] rgb_a, rgb_b;
  logic       hs_a, vs_a, de_a, vb_a, fs_a, err_a;
  logic       hs_b, vs_b, de_b, vb_b, fs_b, err_b;

  vga_scaler_ctrl #(
    .COLOR_W(3), .FB_W(4), .FB_H(3), .ADDR_W(4), .SCALE(2), .WIN_X(4), .WIN_Y(1),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(0), .VSYNC_POL(1), .CLK_DIV(2)
  ) u_a (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .border_color(border_a), .disp_RGB(rgb_a),
    .hsync(hs_a), .vsync(vs_a), .de(de_a), .vblank(vb_a),
    .frame_start(fs_a), .wr_err(err_a)
  );

  vga_scaler_ctrl #(
    .COLOR_W(3), .FB_W(2), .FB_H(2), .ADDR_W(2), .SCALE(4), .WIN_X(10), .WIN_Y(6),
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1), .VSYNC_POL(0), .CLK_DIV(1)
  ) u_b (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .border_color(border_b), .disp_RGB(rgb_b),
    .hsync(hs_b), .vsync(vs_b), .de(de_b), .vblank(vb_b),
    .frame_start(fs_b), .wr_err(err_b)
  );

  // Observation mux so one capture routine serves both instances.
  bit         sel;
  logic [2:0] m_rgb;
  logic       m_hs, m_vs, m_de, m_vb, m_fs;
  assign m_rgb = sel ? rgb_b : rgb_a;
  assign m_hs  = sel ? hs_b  : hs_a;
  assign m_vs  = sel ? vs_b  : vs_a;
  assign m_de  = sel ? de_b  : de_a;
  assign m_vb  = sel ? vb_b  : vb_a;
  assign m_fs  = sel ? fs_b  : fs_a;

  int c_rgb [PIX];
  int c_hs  [PIX];
  int c_vs  [PIX];
  int c_de  [PIX];
  int c_vb  [PIX];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int px(input int h, input int v);
    return v * HT + h;
  endfunction

  task automatic chk_pix(input string tag, input int h, input int v, input int exp);
    check(tag, c_rgb[px(h, v)], exp);
  endtask

  task automatic wr(input bit s, input int a, input int d);
    if (!s) begin
      wr_en_a = 1'b1; wr_addr_a = 4'(a); wr_data_a = 3'(d);
    end else begin
      wr_en_b = 1'b1; wr_addr_b = 2'(a); wr_data_b = 3'(d);
    end
    @(negedge clock);
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
  endtask

  // Waits for the next frame_start, then records one sample per pixel for a full frame.
  task automatic capture(input bit s, input int div, output int lat);
    bit found;
    int fs1;
    sel   = s;
    found = 0;
    lat   = 0;
    fs1   = -1;
    for (int k = 1; k <= 2000 && !found; k++) begin
      @(negedge clock);
      if (m_fs) begin
        found = 1;
        lat   = k;
      end
    end
    check("fs_seen", int'(found), 1);
    for (int p = 0; p < PIX; p++) begin
      if (p == 1) begin
        @(negedge clock);
        fs1 = int'(m_fs);
        repeat (div - 1) @(negedge clock);
      end else if (p > 1) begin
        repeat (div) @(negedge clock);
      end
      c_rgb[p] = int'(m_rgb);
      c_hs[p]  = int'(m_hs);
      c_vs[p]  = int'(m_vs);
      c_de[p]  = int'(m_de);
      c_vb[p]  = int'(m_vb);
    end
    check("fs_width", fs1, 0);
  endtask

  // Clocks between two consecutive frame_start pulses.
  task automatic period(input bit s, input int exp, input string tag);
    bit found;
    int n;
    sel   = s;
    found = 0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clock);
      if (m_fs) found = 1;
    end
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!m_fs && n < 2000);
    check(tag, found ? n : -1, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat_a, lat_b, lat, cnt;
    bit hit;
    int fb_a [12] = '{5, 3, 6, 1, 7, 4, 1, 5, 3, 6, 7, 4};
    int fb_b [4]  = '{6, 5, 3, 7};

    reset_n   = 1'b0;
    wr_en_a   = 1'b0; wr_addr_a = '0; wr_data_a = '0;
    wr_en_b   = 1'b0; wr_addr_b = '0; wr_data_b = '0;
    border_a  = 3'b010;
    border_b  = 3'b100;
    sel       = 0;

    repeat (5) @(negedge clock);
    check("rst_rgb_a", int'(rgb_a), 0);
    check("rst_de_a",  int'(de_a), 0);
    check("rst_hs_a",  int'(hs_a), 1);
    check("rst_vs_a",  int'(vs_a), 0);
    check("rst_vb_a",  int'(vb_a), 0);
    check("rst_fs_a",  int'(fs_a), 0);
    check("rst_err_a", int'(err_a), 0);
    check("rst_hs_b",  int'(hs_b), 0);
    check("rst_vs_b",  int'(vs_b), 1);
    check("rst_de_b",  int'(de_b), 0);

    // First frame_start latency after release: 2 ticks (4 clocks for A, 2 for B).
    reset_n = 1'b1;
    lat_a = 0;
    lat_b = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (fs_a && lat_a == 0) lat_a = k;
      if (fs_b && lat_b == 0) lat_b = k;
    end
    check("fs_lat_a", lat_a, 4);
    check("fs_lat_b", lat_b, 2);

    for (int i = 0; i < 12; i++) wr(0, i, fb_a[i]);
    for (int i = 0; i < 4; i++)  wr(1, i, fb_b[i]);
    check("err_clean_a", int'(err_a), 0);
    wr(0, 12, 7);
    check("err_set_a", int'(err_a), 1);
    wr(0, 15, 7);

    // Instance A scan-out.
    capture(0, 2, lat);
    chk_pix("a_border_0_0", 0, 0, 2);
    chk_pix("a_win_4_1",    4, 1, 5);
    chk_pix("a_rep_5_1",    5, 1, 5);
    chk_pix("a_col1_6_1",   6, 1, 3);
    chk_pix("a_rep_7_2",    7, 2, 3);
    chk_pix("a_col3_10_2", 10, 2, 1);
    chk_pix("a_row1_6_3",   6, 3, 4);
    chk_pix("a_row1_11_3", 11, 3, 5);
    chk_pix("a_row1_8_4",   8, 4, 1);
    chk_pix("a_row2_4_5",   4, 5, 3);
    chk_pix("a_row2_9_6",   9, 6, 7);
    chk_pix("a_rborder",   12, 3, 2);
    chk_pix("a_lborder",    3, 1, 2);
    chk_pix("a_bborder",    4, 7, 2);
    chk_pix("a_hblank",    16, 0, 0);
    chk_pix("a_vblank",     5, 8, 0);
    check("a_hs_17", c_hs[px(17, 0)], 1);
    check("a_hs_18", c_hs[px(18, 0)], 0);
    check("a_hs_20", c_hs[px(20, 0)], 0);
    check("a_hs_21", c_hs[px(21, 0)], 1);
    check("a_vs_8",  c_vs[px(0, 8)], 0);
    check("a_vs_9",  c_vs[px(0, 9)], 1);
    check("a_vs_10", c_vs[px(23, 10)], 1);
    check("a_vs_11", c_vs[px(0, 11)], 0);
    check("a_de_15", c_de[px(15, 0)], 1);
    check("a_de_16", c_de[px(16, 0)], 0);
    check("a_de_v8", c_de[px(0, 8)], 0);
    check("a_vb_7",  c_vb[px(23, 7)], 0);
    check("a_vb_8",  c_vb[px(0, 8)], 1);
    check("a_vb_0",  c_vb[px(0, 0)], 0);
    cnt = 0;
    for (int h = 0; h < HT; h++) if (c_hs[px(h, 4)] == 0) cnt++;
    check("a_hs_low_clks", cnt * 2, 6);
    cnt = 0;
    for (int h = 0; h < HT; h++) if (c_de[px(h, 0)] == 1) cnt++;
    check("a_de_clks", cnt * 2, 32);
    cnt = 0;
    for (int v = 0; v < VT; v++) if (c_vs[px(0, v)] == 1) cnt++;
    check("a_vs_lines", cnt, 2);
    check("err_sticky_a", int'(err_a), 1);
    period(0, 576, "a_period");

    // Instance B scan-out: CLK_DIV 1, horizontal and vertical clipping.
    capture(1, 1, lat);
    chk_pix("b_border_0_0", 0, 0, 4);
    chk_pix("b_lborder",    9, 6, 4);
    chk_pix("b_above_win", 12, 5, 4);
    chk_pix("b_col0_10_6", 10, 6, 6);
    chk_pix("b_col0_13_7", 13, 7, 6);
    chk_pix("b_col1_14_6", 14, 6, 5);
    chk_pix("b_col1_15_7", 15, 7, 5);
    chk_pix("b_clip_h",    16, 6, 0);
    chk_pix("b_clip_v",    10, 8, 0);
    check("b_hs_17", c_hs[px(17, 0)], 0);
    check("b_hs_18", c_hs[px(18, 0)], 1);
    check("b_hs_20", c_hs[px(20, 3)], 1);
    check("b_hs_21", c_hs[px(21, 3)], 0);
    check("b_vs_8",  c_vs[px(0, 8)], 1);
    check("b_vs_9",  c_vs[px(0, 9)], 0);
    cnt = 0;
    for (int h = 0; h < HT; h++) if (c_hs[px(h, 2)] == 1) cnt++;
    check("b_hs_clks", cnt, 3);
    check("b_err", int'(err_b), 0);
    period(1, 288, "b_period");

    // Reset in vertical blanking, mid-frame: outputs drop to idle, frame restarts cleanly.
    sel = 0;
    hit = 0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge clock);
      if (vb_a) hit = 1;
    end
    check("vb_reached", int'(hit), 1);
    repeat (7) @(negedge clock);
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("mid_rst_hs_a",  int'(hs_a), 1);
    check("mid_rst_vs_a",  int'(vs_a), 0);
    check("mid_rst_de_a",  int'(de_a), 0);
    check("mid_rst_rgb_a", int'(rgb_a), 0);
    check("mid_rst_vb_a",  int'(vb_a), 0);
    check("mid_rst_err_a", int'(err_a), 0);
    reset_n = 1'b1;
    capture(0, 2, lat);
    check("mid_fs_lat", lat, 4);
    check("mid_hs_17", c_hs[px(17, 0)], 1);
    check("mid_hs_18", c_hs[px(18, 0)], 0);
    check("mid_de_0",  c_de[px(0, 0)], 1);
    chk_pix("mid_border", 0, 0, 2);
    chk_pix("mid_fb_kept", 4, 1, 5);
    chk_pix("mid_fb_row2", 9, 6, 7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
